// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for an RV32I subset datapath (R, I-ALU, lw, sw, beq)
// sharing a single memory port for instruction fetch and data access.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_b,
    output logic [3:0]       alu_ctr,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired,
    output logic             error
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0110;

    localparam int            TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LIMIT = TW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    cls_t          cls_q, cls_dec;
    logic [TW-1:0] tcnt_q;
    logic          retire;
    logic [3:0]    r_ctr, i_ctr;

    // Only opcode, funct3 and bit 30 steer control; the rest is datapath-only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    assign state = state_q;
    assign error = (state_q == S_ERROR);

    // Opcode to instruction class; anything outside the subset is NONE.
    always_comb begin
        cls_dec = C_NONE;
        case (instruction[6:0])
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LOAD;
            7'b0100011: cls_dec = C_STORE;
            7'b1100011: cls_dec = C_BRANCH;
            default:    cls_dec = C_NONE;
        endcase
    end

    // ALU operation for R-type and I-type ALU instructions.
    always_comb begin
        r_ctr = ALU_ADD;
        case ({instruction[30], instruction[14:12]})
            4'b0000: r_ctr = ALU_ADD;
            4'b1000: r_ctr = ALU_SUB;
            4'b0111: r_ctr = ALU_AND;
            4'b0110: r_ctr = ALU_OR;
            4'b0100: r_ctr = ALU_XOR;
            4'b0001: r_ctr = ALU_SLL;
            default: r_ctr = ALU_ADD;
        endcase
        i_ctr = ALU_ADD;
        case (instruction[14:12])
            3'b100:  i_ctr = ALU_XOR;
            3'b110:  i_ctr = ALU_OR;
            3'b111:  i_ctr = ALU_AND;
            default: i_ctr = ALU_ADD;
        endcase
    end

    // State, class, timeout counter and retire counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            tcnt_q  <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                cls_q <= cls_dec;
            // Every entry into FETCH or MEM is a state change, so clearing on
            // any transition restarts the wait budget for each new access.
            if (state_d != state_q)
                tcnt_q <= '0;
            else if (mem_req && !mem_ready)
                tcnt_q <= tcnt_q + TW'(1);
            if (retire)
                retired <= retired + RET_W'(1);
        end
    end

    // Next-state and control outputs; everything held at 0 while in reset.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 1'b0;
        alu_ctr    = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (tcnt_q == T_LIMIT) begin
                        state_d = S_ERROR;
                    end
                end
                S_DECODE: state_d = (cls_dec == C_NONE) ? S_ERROR : S_EXEC;
                S_EXEC: begin
                    case (cls_q)
                        C_R: begin
                            alu_ctr = r_ctr;
                            state_d = S_WB;
                        end
                        C_I: begin
                            alu_src_b = 1'b1;
                            alu_ctr   = i_ctr;
                            state_d   = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            alu_src_b = 1'b1;
                            state_d   = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_ctr  = ALU_SUB;
                            pc_write = zero;
                            pc_src   = 1'b1;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (cls_q == C_STORE);
                    if (mem_ready) begin
                        if (cls_q == C_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else if (tcnt_q == T_LIMIT) begin
                        state_d = S_ERROR;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == C_LOAD);
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_ERROR;
            endcase
        end
    end

endmodule
